// File: rtl/memory_control.sv
// Single-ported memory responder: arbitrates data/instruction requests onto one fixed-latency RAM port.
// Optional MEMCTL_STATS_EN adds hit/abort counters (icount, dcount, abortcount).
module memory_control #(
    parameter int LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload
`ifdef MEMCTL_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [15:0] abortcount
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {ACC_NONE, ACC_IR, ACC_DR, ACC_DW} acc_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t      state, state_n;
    acc_t        acc, acc_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] store_q, store_n;
    logic [31:0] load_q, load_n;
    logic        abort;
    logic        busy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            acc     <= ACC_NONE;
            cnt     <= '0;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            addr_q  <= addr_n;
            store_q <= store_n;
            load_q  <= load_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        addr_n  = addr_q;
        store_n = store_q;
        load_n  = load_q;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                // dWEN wins over dREN, so a simultaneous read+write is a write
                if (dWEN || dREN || iREN) begin
                    state_n = BUSY;
                    cnt_n   = CNT_INIT;
                    store_n = dstore;
                    if (dWEN) begin
                        acc_n  = ACC_DW;
                        addr_n = daddr;
                    end else if (dREN) begin
                        acc_n  = ACC_DR;
                        addr_n = daddr;
                    end else begin
                        acc_n  = ACC_IR;
                        addr_n = iaddr;
                    end
                end
            end
            BUSY: begin
                // reads are dropped when their requestor lets go; writes always finish
                if ((acc == ACC_IR && !iREN) || (acc == ACC_DR && !dREN && !dWEN)) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (cnt == 4'd0) begin
                    load_n  = ramload;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state == BUSY);
    assign ramREN   = busy && (acc == ACC_IR || acc == ACC_DR);
    assign ramWEN   = busy && (acc == ACC_DW);
    assign ramaddr  = busy ? addr_q : '0;
    assign ramstore = busy ? store_q : '0;
    assign ihit     = (state == RESP) && (acc == ACC_IR);
    assign dhit     = (state == RESP) && (acc == ACC_DR || acc == ACC_DW);
    assign iload    = load_q;
    assign dload    = load_q;

`ifdef MEMCTL_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            icount     <= '0;
            dcount     <= '0;
            abortcount <= '0;
        end else begin
            if (ihit)  icount     <= icount + 32'd1;
            if (dhit)  dcount     <= dcount + 32'd1;
            if (abort) abortcount <= abortcount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_control.sv
// Bench for memory_control: vector table at LAT=2, hand sequences for arbitration/abort/reset,
// and random back-to-back traffic on LAT=1 and LAT=15 instances, all checked through a scoreboard queue.
module tb_memory_control;

    localparam int LAT = 2;

    typedef struct {
        logic        is_i;
        logic        chk_load;
        logic [31:0] load;
        int          lat;
    } exp_t;

    typedef struct {
        logic        dwen, dren, iren;
        logic [31:0] ia, da, ds;
        logic        e_ren, e_wen;
        logic [31:0] e_addr;
        logic        e_is_i, e_chk_load;
        logic [31:0] e_load;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_i = 0, exp_d = 0, exp_a = 0;
    exp_t sbq[$];

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        ihit, dhit, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
`ifdef MEMCTL_STATS_EN
    logic [31:0] icount, dcount;
    logic [15:0] abortcount;
`endif

    function automatic logic [31:0] ram_f(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C22_0004 : ((a ^ 32'h5A5A_0000) + 32'h1);
    endfunction

    always #5 CLK = ~CLK;
    assign ramload = ram_f(ramaddr);

    memory_control #(.LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload)
`ifdef MEMCTL_STATS_EN
        , .icount(icount), .dcount(dcount), .abortcount(abortcount)
`endif
    );

    // index 0: LAT=1, index 1: LAT=15
    logic        r_iren [2], r_dren [2], r_dwen [2];
    logic [31:0] r_iaddr [2], r_daddr [2], r_dstore [2];
    logic        r_ihit [2], r_dhit [2], r_ramren [2], r_ramwen [2];
    logic [31:0] r_iload [2], r_dload [2], r_ramaddr [2], r_ramstore [2], r_ramload [2];
`ifdef MEMCTL_STATS_EN
    logic [31:0] r_icount [2], r_dcount [2];
    logic [15:0] r_abort [2];
`endif

    assign r_ramload[0] = ram_f(r_ramaddr[0]);
    assign r_ramload[1] = ram_f(r_ramaddr[1]);

    memory_control #(.LAT(1)) dut_l1 (
        .CLK(CLK), .RST(RST), .iREN(r_iren[0]), .iaddr(r_iaddr[0]), .dREN(r_dren[0]), .dWEN(r_dwen[0]),
        .daddr(r_daddr[0]), .dstore(r_dstore[0]), .ihit(r_ihit[0]), .iload(r_iload[0]), .dhit(r_dhit[0]),
        .dload(r_dload[0]), .ramREN(r_ramren[0]), .ramWEN(r_ramwen[0]), .ramaddr(r_ramaddr[0]),
        .ramstore(r_ramstore[0]), .ramload(r_ramload[0])
`ifdef MEMCTL_STATS_EN
        , .icount(r_icount[0]), .dcount(r_dcount[0]), .abortcount(r_abort[0])
`endif
    );

    memory_control #(.LAT(15)) dut_l15 (
        .CLK(CLK), .RST(RST), .iREN(r_iren[1]), .iaddr(r_iaddr[1]), .dREN(r_dren[1]), .dWEN(r_dwen[1]),
        .daddr(r_daddr[1]), .dstore(r_dstore[1]), .ihit(r_ihit[1]), .iload(r_iload[1]), .dhit(r_dhit[1]),
        .dload(r_dload[1]), .ramREN(r_ramren[1]), .ramWEN(r_ramwen[1]), .ramaddr(r_ramaddr[1]),
        .ramstore(r_ramstore[1]), .ramload(r_ramload[1])
`ifdef MEMCTL_STATS_EN
        , .icount(r_icount[1]), .dcount(r_dcount[1]), .abortcount(r_abort[1])
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " ihit"}, 32'(ihit), 0);
        chk({nm, " dhit"}, 32'(dhit), 0);
        chk({nm, " ramREN"}, 32'(ramREN), 0);
        chk({nm, " ramWEN"}, 32'(ramWEN), 0);
        chk({nm, " ramaddr"}, ramaddr, 0);
        chk({nm, " ramstore"}, ramstore, 0);
        chk({nm, " iload"}, iload, 0);
        chk({nm, " dload"}, dload, 0);
    endtask

    // count negedges until a hit pulse on the main DUT, bounded
    task automatic wait_hit(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!(ihit || dhit) && cyc < max);
    endtask

    task automatic run_rand(input int k, input int lat);
        int cyc, t;
        logic [31:0] a;
        exp_t e;
        @(negedge CLK);
        for (int n = 0; n < 20; n++) begin
            t = int'($urandom_range(0, 2));
            a = $urandom & 32'h0000_FFFC;
            r_iren[k] = (t == 0); r_dren[k] = (t == 1); r_dwen[k] = (t == 2);
            r_iaddr[k] = a; r_daddr[k] = a; r_dstore[k] = $urandom;
            // after a hit, the RESP and IDLE cycles precede the next grant
            sbq.push_back('{is_i: (t == 0), chk_load: (t != 2), load: ram_f(a),
                            lat: (n == 0) ? lat + 1 : lat + 2});
            cyc = 0;
            do begin
                @(negedge CLK);
                cyc++;
                if (cyc == ((n == 0) ? 1 : 2)) chk("rand ramaddr", r_ramaddr[k], a);
            end while (!(r_ihit[k] || r_dhit[k]) && cyc < lat + 8);
            e = sbq.pop_front();
            chk("rand hit spacing", 32'(cyc), 32'(e.lat));
            chk("rand ihit", 32'(r_ihit[k]), 32'(e.is_i));
            chk("rand dhit", 32'(r_dhit[k]), 32'(!e.is_i));
            if (e.chk_load) chk("rand load", e.is_i ? r_iload[k] : r_dload[k], e.load);
        end
        r_iren[k] = 0; r_dren[k] = 0; r_dwen[k] = 0;
        @(negedge CLK);
    endtask

    initial begin
        vec_t vt[5];
        exp_t e;
        int cyc;

        for (int k = 0; k < 2; k++) begin
            r_iren[k] = 0; r_dren[k] = 0; r_dwen[k] = 0;
            r_iaddr[k] = '0; r_daddr[k] = '0; r_dstore[k] = '0;
        end

        vt[0] = '{dwen:0, dren:0, iren:1, ia:32'h40, da:32'h0, ds:32'h0, e_ren:1, e_wen:0,
                  e_addr:32'h40, e_is_i:1, e_chk_load:1, e_load:32'h8C22_0004};
        vt[1] = '{dwen:0, dren:1, iren:0, ia:32'h0, da:32'h200, ds:32'h0, e_ren:1, e_wen:0,
                  e_addr:32'h200, e_is_i:0, e_chk_load:1, e_load:32'h5A5A_0201};
        vt[2] = '{dwen:1, dren:0, iren:0, ia:32'h0, da:32'h104, ds:32'h1234_5678, e_ren:0, e_wen:1,
                  e_addr:32'h104, e_is_i:0, e_chk_load:0, e_load:32'h0};
        vt[3] = '{dwen:1, dren:1, iren:0, ia:32'h0, da:32'h108, ds:32'hCAFE_F00D, e_ren:0, e_wen:1,
                  e_addr:32'h108, e_is_i:0, e_chk_load:0, e_load:32'h0};
        vt[4] = '{dwen:0, dren:1, iren:1, ia:32'h44, da:32'h300, ds:32'h0, e_ren:1, e_wen:0,
                  e_addr:32'h300, e_is_i:0, e_chk_load:1, e_load:32'h5A5A_0301};

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge CLK);
        RST = 0;

        for (int v = 0; v < 5; v++) begin
            @(negedge CLK);
            dWEN = vt[v].dwen; dREN = vt[v].dren; iREN = vt[v].iren;
            iaddr = vt[v].ia; daddr = vt[v].da; dstore = vt[v].ds;
            sbq.push_back('{is_i: vt[v].e_is_i, chk_load: vt[v].e_chk_load, load: vt[v].e_load, lat: LAT + 1});
            for (int c = 0; c < LAT; c++) begin
                @(negedge CLK);
                chk("vec ramREN", 32'(ramREN), 32'(vt[v].e_ren));
                chk("vec ramWEN", 32'(ramWEN), 32'(vt[v].e_wen));
                chk("vec ramaddr", ramaddr, vt[v].e_addr);
                if (vt[v].e_wen) chk("vec ramstore", ramstore, vt[v].ds);
            end
            @(negedge CLK);
            e = sbq.pop_front();
            chk("vec ihit", 32'(ihit), 32'(e.is_i));
            chk("vec dhit", 32'(dhit), 32'(!e.is_i));
            chk("vec resp ram enables", 32'({ramREN, ramWEN}), 0);
            if (e.chk_load) chk("vec load", e.is_i ? iload : dload, e.load);
            if (e.is_i) exp_i++; else exp_d++;
            dWEN = 0; dREN = 0; iREN = 0;
            @(negedge CLK);
        end

        // simultaneous write and fetch: write first, fetch LAT+2 cycles after dhit
        @(negedge CLK);
        dWEN = 1; iREN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; iaddr = 32'h40;
        for (int c = 0; c < LAT; c++) begin
            @(negedge CLK);
            chk("wr+if ramWEN", 32'(ramWEN), 1);
            chk("wr+if ramREN", 32'(ramREN), 0);
            chk("wr+if ramaddr", ramaddr, 32'h100);
            chk("wr+if ramstore", ramstore, 32'hDEAD_BEEF);
        end
        @(negedge CLK);
        chk("wr+if dhit", 32'(dhit), 1);
        chk("wr+if no ihit", 32'(ihit), 0);
        exp_d++;
        dWEN = 0;
        wait_hit(LAT + 8, cyc);
        chk("wr+if ihit gap", 32'(cyc), 32'(LAT + 2));
        chk("wr+if ihit", 32'(ihit), 1);
        chk("wr+if iload", iload, 32'h8C22_0004);
        exp_i++;
        iREN = 0;
        @(negedge CLK);

        // read aborted after first BUSY cycle
        @(negedge CLK);
        dREN = 1; daddr = 32'h500;
        @(negedge CLK);
        chk("abort busy ramREN", 32'(ramREN), 1);
        dREN = 0;
        @(negedge CLK);
        chk("abort idle ramREN", 32'(ramREN), 0);
        exp_a++;
        for (int c = 0; c < 3; c++) begin
            chk("abort no dhit", 32'(dhit), 0);
            @(negedge CLK);
        end

        // write with dWEN dropped mid-access still completes
        dWEN = 1; daddr = 32'h504; dstore = 32'h1;
        @(negedge CLK);
        dWEN = 0;
        @(negedge CLK);
        chk("wr drop ramWEN", 32'(ramWEN), 1);
        @(negedge CLK);
        chk("wr drop dhit", 32'(dhit), 1);
        exp_d++;
        @(negedge CLK);

`ifdef MEMCTL_STATS_EN
        chk("icount", icount, 32'(exp_i));
        chk("dcount", dcount, 32'(exp_d));
        chk("abortcount", 32'(abortcount), 32'(exp_a));
`endif

        // reset in the middle of a write
        @(negedge CLK);
        dWEN = 1; daddr = 32'h600; dstore = 32'h77;
        @(negedge CLK);
        chk("rst-mid ramWEN before", 32'(ramWEN), 1);
        #2 RST = 1;
        #1;
        chk_all_zero("rst-mid");
        dWEN = 0;
        @(negedge CLK);
        RST = 0; iREN = 1; iaddr = 32'h40;
        wait_hit(LAT + 8, cyc);
        chk("post-rst fetch latency", 32'(cyc), 32'(LAT + 1));
        chk("post-rst ihit", 32'(ihit), 1);
        chk("post-rst no dhit", 32'(dhit), 0);
        chk("post-rst iload", iload, 32'h8C22_0004);
        iREN = 0;
        @(negedge CLK);

        run_rand(0, 1);
        run_rand(1, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
